conv_interleaver: RTL
=====================

# conv_interleaver

Byte-wide Forney convolutional interleaver for the transmit FEC chain. It sits between the Reed-Solomon encoder output (upstream) and the mapper/modulator input (downstream). A commutator steps each accepted byte through BRANCHES branches; branch j delays its bytes by j·DEPTH_UNIT branch visits. It also keeps the packet sync byte aligned to the zero-delay branch 0.

## Interface
- BRANCHES, 12: number of commutator branches.
- DEPTH_UNIT, 17: per-branch delay increment, in branch visits.
- DATA_W, 8: byte width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  upstream byte valid.
- in_data  in  DATA_W  upstream byte.
- in_sync  in  1  marks the first byte of a 204-byte packet.
- in_ready  out  1  block can accept a byte this cycle.
- out_valid  out  1  output byte valid.
- out_data  out  DATA_W  interleaved byte.
- out_sync  out  1  output byte is a packet sync byte (branch 0, undelayed).
- out_ready  in  1  downstream accepts the output byte.
- branch_idx  out  $clog2(BRANCHES)  commutator position for the next accepted byte.
- sync_err  out  1  one-cycle pulse when a misaligned sync is detected.

## Operation
- A byte is accepted when in_valid && in_ready.
- Accepted byte goes to branch b = branch_idx.
- Only branch b shifts (enable-gated), with the new byte entering at its head. All other branches hold.
- Branch 0 has zero delay: the input byte goes straight to the output register.
- For branch j > 0, the output byte is the one leaving the tail of branch j's j·DEPTH_UNIT-deep shift line.
- branch_idx increments by 1 per accepted byte and wraps from BRANCHES−1 to 0.
- Output register (out_data, out_sync, out_valid) loads on every accepted byte. out_sync = in_sync of that byte.
- in_ready = out_ready || !out_valid. There is no skid buffer.
- Output-register clear:
  - When out_valid && out_ready and no new accept occurs, out_valid clears.
  - out_data holds its last value.
- FSM (only with the sync-check macro defined):
  - ALIGN: in_ready = 1. Bytes with in_sync=0 are consumed and dropped (no shift, no output). A byte with in_sync=1 is accepted as branch 0, and the FSM moves to RUN.
  - RUN: normal operation. If in_sync=1 on an accepted byte while branch_idx≠0:
    - sync_err pulses for one cycle.
    - The byte is processed as branch 0 and branch_idx is set to 1.
    - The FSM stays in RUN.
    - Delay-line contents are not flushed.
- With the default parameters, 204 = 12·17, so aligned sync bytes always land on branch 0.
- Simultaneous accept and output drain in one cycle is legal. The new byte replaces the old one and out_valid stays 1.

## Timing
- Reset (reset=0 at a clk edge):
  - out_valid=0, out_data=0, out_sync=0, sync_err=0, branch_idx=0.
  - All branch delay-line contents are 0.
  - FSM enters ALIGN.
- Reset takes priority over any concurrent accept. Reset mid-stream discards all buffered bytes.
- Pipeline latency: out_* is valid on the cycle after the accept edge.
- End-to-end delay of a byte on branch j: j·DEPTH_UNIT·BRANCHES accepted bytes.
  - Until a branch has been filled, it emits 0x00.
  - Branch 11 fills after 11·17·12 = 2244 accepted bytes.
- Stall:
  - With out_ready=0 and out_valid=1: in_ready=0; branch_idx, delay lines and out_* hold.
  - sync_err is asserted only on the cycle following the offending accept.

## Configuration
- CONV_INTLV_SYNC_CHECK_EN defined:
  - ALIGN/RUN FSM, byte dropping in ALIGN, misaligned-sync realignment and sync_err are all present.
- Undefined:
  - No FSM. branch_idx free-runs from 0 after reset, and every valid byte is accepted and interleaved.
  - in_sync only propagates to out_sync.
  - sync_err is tied to 0.

## Structure
- Package conv_intlv_pkg:
  - Defaults BRANCHES=12, DEPTH_UNIT=17, DATA_W=8, PKT_LEN=204.
  - SYNC_BYTE=8'h47 (for benches).
  - State enum {ST_ALIGN, ST_RUN}.
- Sub-module intlv_branch_sr (params DATA_W, LEN): enable-gated LEN-stage byte shift register with synchronous active-low reset.
  - Instantiated once per branch j = 1..BRANCHES−1 with LEN = j·DEPTH_UNIT, using a generate loop.
- The top level holds the commutator counter, the FSM, the output mux over branch tails, and the output register.

## Test plan
- Reset, then in_valid with 0x47/in_sync=1, out_ready=1 → next cycle out_valid=1, out_data=0x47, out_sync=1, branch_idx=1.
- After a sync at byte 0, stream bytes n=0..2499 (in_data = n mod 256, in_sync every 204th byte):
  - Output for input n=1 (branch 1) is 0x00.
  - Output for input n=205 (branch 1) is 0x01.
  - Output for input n=2255 (branch 11) is 0x0B.
- out_ready=0 for 5 cycles mid-stream → in_ready=0 for those cycles; out_data, out_valid and branch_idx are held. Resuming continues the sequence with no lost or duplicated bytes.
- In RUN, drive in_sync=1 at branch_idx=5 (macro on) → sync_err high for exactly one cycle, byte emitted undelayed with out_sync=1, branch_idx becomes 1.
- reset=0 for one cycle mid-stream, then 3 bytes without sync (macro on) → no out_valid. The following sync byte is emitted at branch 0, and branch 1 outputs 0x00 (delay lines flushed).
- Macro off: first byte 0x12 with in_sync=0 after reset → accepted on branch 0, out_data=0x12 next cycle, sync_err stays 0 throughout.

Source files
------------

// File: rtl/conv_intlv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_intlv_pkg
//  Description : Shared constants and types for the Forney convolutional
//                interleaver (default geometry, packet length, sync byte,
//                commutator alignment states).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_intlv_pkg;

    localparam int         c_BRANCHES   = 12;
    localparam int         c_DEPTH_UNIT = 17;
    localparam int         c_DATA_W     = 8;
    localparam int         c_PKT_LEN    = 204;
    localparam logic [7:0] c_SYNC_BYTE  = 8'h47;

    // Commutator alignment: hunt for a sync byte, then interleave.
    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/intlv_branch_sr.sv
`default_nettype none
// ============================================================================
//  Module      : intlv_branch_sr
//  Description : Enable-gated LEN-stage shift register forming one delayed
//                branch of the convolutional interleaver. o_dout is the byte
//                that leaves the line on the next enabled shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module intlv_branch_sr
    import conv_intlv_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LEN    = c_DEPTH_UNIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_sr [LEN];

    // Advance one stage per branch visit; reset flushes the line to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LEN; i++) begin
                r_sr[i] <= '0;
            end
        end else if (i_en) begin
            r_sr[0] <= i_din;
            for (int i = 1; i < LEN; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_dout = r_sr[LEN-1];

endmodule
`default_nettype wire

// File: rtl/conv_interleaver.sv
`default_nettype none
// ============================================================================
//  Module      : conv_interleaver
//  Description : Byte-wide Forney convolutional interleaver. A commutator
//                steps accepted bytes over BRANCHES branches; branch j delays
//                by j*DEPTH_UNIT visits. Branch 0 is undelayed and carries
//                the packet sync byte.
//                Optional feature macro: CONV_INTLV_SYNC_CHECK_EN enables the
//                ALIGN/RUN sync-alignment FSM and the sync_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_interleaver
    import conv_intlv_pkg::*;
#(
    parameter int BRANCHES   = c_BRANCHES,
    parameter int DEPTH_UNIT = c_DEPTH_UNIT,
    parameter int DATA_W     = c_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_sync,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_sync,
    input  logic                        out_ready,
    output logic [$clog2(BRANCHES)-1:0] branch_idx,
    output logic                        sync_err
);

    localparam int                 c_IDX_W = $clog2(BRANCHES);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(BRANCHES - 1);

    logic                             w_in_ready;
    logic                             w_accept;
    logic                             w_load;
    logic                             w_sync_err_set;
    logic [c_IDX_W-1:0]               w_br;
    logic [c_IDX_W-1:0]               w_idx_next;
    logic [BRANCHES-1:0][DATA_W-1:0]  w_tail;
    logic [DATA_W-1:0]                w_mux;

    logic                             r_out_valid;
    logic [DATA_W-1:0]                r_out_data;
    logic                             r_out_sync;
    logic                             r_sync_err;
    logic [c_IDX_W-1:0]               r_branch_idx;

    assign w_accept = in_valid && w_in_ready;

`ifdef CONV_INTLV_SYNC_CHECK_EN
    state_t r_state;
    state_t w_state_next;

    // While aligning, the block always consumes so non-sync bytes drain away.
    assign w_in_ready = (r_state == ST_ALIGN) || out_ready || !r_out_valid;

    // Alignment state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ALIGN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sync bytes always land on branch 0; a sync seen off branch 0 realigns.
    always_comb begin
        w_state_next   = r_state;
        w_load         = w_accept;
        w_br           = r_branch_idx;
        w_sync_err_set = 1'b0;
        if (r_state == ST_ALIGN) begin
            w_load = w_accept && in_sync;
            w_br   = '0;
            if (w_accept && in_sync) begin
                w_state_next = ST_RUN;
            end
        end else if (in_sync) begin
            w_br           = '0;
            w_sync_err_set = w_accept && (r_branch_idx != '0);
        end
    end
`else
    assign w_in_ready     = out_ready || !r_out_valid;
    assign w_load         = w_accept;
    assign w_br           = r_branch_idx;
    assign w_sync_err_set = 1'b0;
`endif

    // Branch 0 is a straight wire; branches 1..BRANCHES-1 are delay lines.
    assign w_tail[0] = in_data;

    generate
        for (genvar j = 1; j < BRANCHES; j++) begin : g_branch
            intlv_branch_sr #(
                .DATA_W (DATA_W),
                .LEN    (j * DEPTH_UNIT)
            ) u_sr (
                .clk    (clk),
                .reset  (reset),
                .i_en   (w_load && (w_br == c_IDX_W'(j))),
                .i_din  (in_data),
                .o_dout (w_tail[j])
            );
        end
    endgenerate

    assign w_mux      = w_tail[w_br];
    assign w_idx_next = (w_br == c_LAST) ? '0 : w_br + c_IDX_W'(1);

    // Output register and commutator: load on every byte that enters a branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sync   <= 1'b0;
            r_sync_err   <= 1'b0;
            r_branch_idx <= '0;
        end else begin
            r_sync_err <= w_sync_err_set;
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_mux;
                r_out_sync   <= in_sync;
                r_branch_idx <= w_idx_next;
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sync   = r_out_sync;
    assign sync_err   = r_sync_err;
    assign branch_idx = r_branch_idx;

endmodule
`default_nettype wire
